// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction/data memory arbiter.
//   owner_e        : which requester owns the memory port (IF or DM)
//   REQ_IF/REQ_DM  : tag values stored in the outstanding-read FIFO
package imem_arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/imem_arb_tagfifo.sv
// arb_tagfifo: small in-order FIFO holding the owner tag of every outstanding read.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write din at the tail
//   pop           : drop the head entry (caller guarantees not empty)
//   head          : entry at the head
//   full, empty   : occupancy flags from the registered count
//   count         : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_tagfifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_arb.sv
// imem_arb: shares one memory port between the fetch stage (IF, read-only)
// and the data stage (DM, read/write).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   if_valid_in/addr, if_ready   : IF read request handshake
//   dm_valid_in/we/addr/wdata,
//   dm_ready_out                 : DM request handshake
//   mem_valid/we/addr/wdata_out,
//   mem_ready_in                 : request towards memory
//   mem_rvalid_in, mem_rdata_in  : in-order read responses, no backpressure
//   if_/dm_rvalid_out, *_rdata   : routed response pulses
//   err_out                      : sticky, response seen with nothing outstanding
// Build option: ARB_ROUND_ROBIN_EN selects alternating grants on contention;
// without it DM has fixed priority over IF.
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int OUTST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid_in,
    input  logic [AW-1:0] if_addr_in,
    output logic          if_ready_out,
    input  logic          dm_valid_in,
    input  logic          dm_we_in,
    input  logic [AW-1:0] dm_addr_in,
    input  logic [DW-1:0] dm_wdata_in,
    output logic          dm_ready_out,
    output logic          mem_valid_out,
    output logic          mem_we_out,
    output logic [AW-1:0] mem_addr_out,
    output logic [DW-1:0] mem_wdata_out,
    input  logic          mem_ready_in,
    input  logic          mem_rvalid_in,
    input  logic [DW-1:0] mem_rdata_in,
    output logic          if_rvalid_out,
    output logic [DW-1:0] if_rdata_out,
    output logic          dm_rvalid_out,
    output logic [DW-1:0] dm_rdata_out,
    output logic          err_out
);

    localparam int CW = $clog2(OUTST) + 1;

    logic          lock;
    owner_e        lock_owner;
    logic          rst_q;
    logic          hold;
    logic          if_cand;
    logic          dm_cand;
    owner_e        sel;
    logic          offer;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
`ifdef ARB_ROUND_ROBIN_EN
    owner_e        last;
`endif

    // Outputs stay quiet during reset and for one cycle after it.
    assign hold = rst | rst_q;

    always_comb begin
        // Reads are blocked on the registered full flag; writes never are.
        if_cand = if_valid_in & ~fifo_full & ~hold;
        dm_cand = dm_valid_in & (dm_we_in | ~fifo_full) & ~hold;
        sel     = OWN_IF;
        offer   = 1'b0;
        if (lock) begin
            // A stalled offer keeps its owner until memory takes it.
            sel   = lock_owner;
            offer = 1'b1;
        end else if (dm_cand && if_cand) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel = (last == OWN_IF) ? OWN_DM : OWN_IF;
`else
            sel = OWN_DM;
`endif
            offer = 1'b1;
        end else if (dm_cand) begin
            sel   = OWN_DM;
            offer = 1'b1;
        end else if (if_cand) begin
            sel   = OWN_IF;
            offer = 1'b1;
        end
    end

    assign mem_valid_out = offer;
    assign mem_we_out    = offer & (sel == OWN_DM) & dm_we_in;
    assign mem_addr_out  = (sel == OWN_DM) ? dm_addr_in : if_addr_in;
    assign mem_wdata_out = dm_wdata_in;

    assign accept       = offer & mem_ready_in;
    assign if_ready_out = accept & (sel == OWN_IF);
    assign dm_ready_out = accept & (sel == OWN_DM);

    assign push = accept & ~mem_we_out;
    assign pop  = mem_rvalid_in & ~fifo_empty & ~rst;

    arb_tagfifo #(
        .W     (1),
        .DEPTH (OUTST)
    ) u_tagfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ((sel == OWN_DM) ? REQ_DM : REQ_IF),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign if_rvalid_out = pop & ~hold & (fifo_head == REQ_IF);
    assign dm_rvalid_out = pop & ~hold & (fifo_head == REQ_DM);
    assign if_rdata_out  = mem_rdata_in;
    assign dm_rdata_out  = mem_rdata_in;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            lock       <= 1'b0;
            lock_owner <= OWN_IF;
            err_out    <= 1'b0;
        end else begin
            if (accept) begin
                lock <= 1'b0;
            end else if (offer) begin
                lock       <= 1'b1;
                lock_owner <= sel;
            end
            if (mem_rvalid_in && fifo_empty) err_out <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)         last <= OWN_IF;
        else if (accept) last <= sel;
    end
`endif

    // Occupancy sanity: count never exceeds depth and agrees with full.
    a_fifo_count : assert property (@(posedge clk) disable iff (rst)
        (fifo_count <= CW'(OUTST)) && (fifo_full == (fifo_count == CW'(OUTST))));

endmodule
